// File: rtl/hidden_cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hidden_cpu_pkg
// Description : Opcodes, FSM state encoding and flag indices for hidden_cpu_core.
// Revision    : 1.0 - initial release
// ============================================================================
package hidden_cpu_pkg;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_MOV  = 4'd6;
    localparam logic [3:0] OP_LDI  = 4'd7;
    localparam logic [3:0] OP_BC   = 4'd8;
    localparam logic [3:0] OP_BB   = 4'd9;
    localparam logic [3:0] OP_BU   = 4'd10;
    localparam logic [3:0] OP_OUT  = 4'd11;
    localparam logic [3:0] OP_HALT = 4'd12;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        IMM   = 2'd1,
        HALT  = 2'd2
    } state_t;

    localparam int FLAG_C = 0;
    localparam int FLAG_B = 1;
    localparam int FLAG_Z = 2;

    // Opcodes above HALT are reserved and flag the sticky illegal bit.
    function automatic logic is_reserved(input logic [3:0] op);
        return op > OP_HALT;
    endfunction

    function automatic logic sets_zero(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_XOR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hidden_cpu_core_if.sv
`default_nettype none
// ============================================================================
// Module      : hidden_cpu_core_if
// Description : Instruction handshake and status bus of hidden_cpu_core.
// Revision    : 1.0 - initial release
// ============================================================================
interface hidden_cpu_core_if #(
    parameter int DATA_W = 8,
    parameter int NREGS  = 4,
    parameter int PC_W   = 8
);
    localparam int ADDR_W  = $clog2(NREGS);
    localparam int INSTR_W = 4 + 2 * ADDR_W;

    logic [INSTR_W-1:0] instr_i;
    logic               instr_valid_i;
    logic               instr_ready_o;
    logic [PC_W-1:0]    pc_o;
    logic [DATA_W-1:0]  out_o;
    logic               out_valid_o;
    logic [2:0]         flags_o;
    logic               halted_o;
    logic               illegal_o;

    modport master (
        output instr_i, instr_valid_i,
        input  instr_ready_o, pc_o, out_o, out_valid_o, flags_o, halted_o, illegal_o
    );

    modport slave (
        input  instr_i, instr_valid_i,
        output instr_ready_o, pc_o, out_o, out_valid_o, flags_o, halted_o, illegal_o
    );
endinterface
`default_nettype wire

// File: rtl/hidden_cpu_core_alu.sv
`default_nettype none
// ============================================================================
// Module      : hidden_alu_n
// Description : Combinational ALU: arithmetic/logic result, carry, borrow, zero.
// Revision    : 1.0 - initial release
// ============================================================================
module hidden_alu_n
    import hidden_cpu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  wire logic [3:0]        i_op,
    input  wire logic [DATA_W-1:0] i_a,
    input  wire logic [DATA_W-1:0] i_b,
    output logic      [DATA_W-1:0] o_result,
    output logic                   o_carry,
    output logic                   o_borrow,
    output logic                   o_zero,
    output logic                   o_write_en
);
    logic [DATA_W:0] w_sum;
    logic [DATA_W:0] w_diff;

    // One extra bit captures carry-out and the unsigned borrow.
    assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
    assign w_diff = {1'b0, i_a} - {1'b0, i_b};

    always_comb begin
        o_result   = '0;
        o_write_en = 1'b1;
        case (i_op)
            OP_ADD:  o_result = w_sum[DATA_W-1:0];
            OP_SUB:  o_result = w_diff[DATA_W-1:0];
            OP_AND:  o_result = i_a & i_b;
            OP_OR:   o_result = i_a | i_b;
            OP_XOR:  o_result = i_a ^ i_b;
            OP_MOV:  o_result = i_b;
            default: o_write_en = 1'b0;
        endcase
    end

    assign o_carry  = w_sum[DATA_W];
    assign o_borrow = w_diff[DATA_W];
    assign o_zero   = (o_result == '0);

endmodule
`default_nettype wire

// File: rtl/hidden_cpu_core.sv
`default_nettype none
// ============================================================================
// Module      : hidden_cpu_core
// Description : Parametrised tiny CPU: register file, PC, FETCH/IMM/HALT FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module hidden_cpu_core
    import hidden_cpu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NREGS  = 4,
    parameter int PC_W   = 8
) (
    input  wire logic          clk,
    input  wire logic          rst,
    hidden_cpu_core_if.slave   bus
);
    localparam int ADDR_W  = $clog2(NREGS);
    localparam int INSTR_W = 4 + 2 * ADDR_W;

    logic [DATA_W-1:0] r_regs [NREGS];
    logic [PC_W-1:0]   r_pc;
    logic [2:0]        r_flags;
    logic [DATA_W-1:0] r_out;
    logic              r_out_valid;
    logic              r_halted;
    logic              r_illegal;
    logic              r_ready;
    logic [ADDR_W-1:0] r_imm_rd;
    state_t            r_state;

    logic [INSTR_W-1:0] w_instr;
    logic [3:0]         w_op;
    logic [ADDR_W-1:0]  w_rd;
    logic [ADDR_W-1:0]  w_rs;
    logic [DATA_W-1:0]  w_a;
    logic [DATA_W-1:0]  w_b;
    logic [DATA_W-1:0]  w_result;
    logic               w_carry;
    logic               w_borrow;
    logic               w_zero;
    logic               w_write_en;
    logic               w_accept;
    logic               w_taken;

    assign w_instr  = bus.instr_i;
    assign w_op     = w_instr[INSTR_W-1 -: 4];
    assign w_rd     = w_instr[2*ADDR_W-1 -: ADDR_W];
    assign w_rs     = w_instr[ADDR_W-1:0];
    assign w_a      = r_regs[w_rd];
    assign w_b      = r_regs[w_rs];
    assign w_accept = bus.instr_valid_i && r_ready;

    hidden_alu_n #(.DATA_W(DATA_W)) u_alu (
        .i_op       (w_op),
        .i_a        (w_a),
        .i_b        (w_b),
        .o_result   (w_result),
        .o_carry    (w_carry),
        .o_borrow   (w_borrow),
        .o_zero     (w_zero),
        .o_write_en (w_write_en)
    );

    always_comb begin
        w_taken = 1'b0;
        case (w_op)
            OP_BC:   w_taken = r_flags[FLAG_C];
            OP_BB:   w_taken = r_flags[FLAG_B];
            OP_BU:   w_taken = 1'b1;
            default: w_taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= DATA_W'(i);
            end
            r_pc        <= '0;
            r_flags     <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_halted    <= 1'b0;
            r_illegal   <= 1'b0;
            r_ready     <= 1'b1;
            r_imm_rd    <= '0;
            r_state     <= FETCH;
        end else begin
            r_out_valid <= 1'b0;
            if (w_accept) begin
                case (r_state)
                    FETCH: begin
                        r_pc <= w_taken ? (r_pc + PC_W'(w_b)) : (r_pc + 1'b1);
                        if (w_write_en) begin
                            r_regs[w_rd] <= w_result;
                        end
                        if (sets_zero(w_op)) begin
                            r_flags[FLAG_Z] <= w_zero;
                        end
                        if (w_op == OP_ADD) begin
                            r_flags[FLAG_C] <= w_carry;
                        end
                        if (w_op == OP_SUB) begin
                            r_flags[FLAG_B] <= w_borrow;
                        end
                        if (w_op == OP_LDI) begin
                            r_imm_rd <= w_rd;
                            r_state  <= IMM;
                        end
                        if (w_op == OP_OUT) begin
                            r_out       <= w_b;
                            r_out_valid <= 1'b1;
                        end
                        if (w_op == OP_HALT) begin
                            r_halted <= 1'b1;
                            r_ready  <= 1'b0;
                            r_state  <= HALT;
                        end
                        if (is_reserved(w_op)) begin
                            r_illegal <= 1'b1;
                        end
                    end
                    IMM: begin
                        // The whole word is the immediate, resized to the data width.
                        r_regs[r_imm_rd] <= DATA_W'(w_instr);
                        r_pc             <= r_pc + 1'b1;
                        r_state          <= FETCH;
                    end
                    default: r_state <= HALT;
                endcase
            end
        end
    end

    assign bus.instr_ready_o = r_ready;
    assign bus.pc_o          = r_pc;
    assign bus.out_o         = r_out;
    assign bus.out_valid_o   = r_out_valid;
    assign bus.flags_o       = r_flags;
    assign bus.halted_o      = r_halted;
    assign bus.illegal_o     = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_hidden_cpu_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_hidden_cpu_core
// Description : Vector table, random run against a reference model, wide-config checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hidden_cpu_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_b;

    hidden_cpu_core_if #(.DATA_W(8),  .NREGS(4), .PC_W(8)) ifa ();
    hidden_cpu_core_if #(.DATA_W(16), .NREGS(8), .PC_W(8)) ifb ();

    hidden_cpu_core #(.DATA_W(8), .NREGS(4), .PC_W(8)) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (ifa.slave)
    );

    hidden_cpu_core #(.DATA_W(16), .NREGS(8), .PC_W(8)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (ifb.slave)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit         rst;
        bit         valid;
        logic [7:0] instr;
        int         pc;
        int         out;
        bit         ov;
        int         flags;
        bit         halt;
        bit         ill;
        bit         rdy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit r, bit v, logic [7:0] ins, int pc, int out, bit ov,
                                int fl, bit h, bit il, bit rd);
        vec_t t;
        t.rst = r; t.valid = v; t.instr = ins; t.pc = pc; t.out = out; t.ov = ov;
        t.flags = fl; t.halt = h; t.ill = il; t.rdy = rd;
        return t;
    endfunction

    task automatic check_a(input string tag, input int pc, input int out, input bit ov,
                           input int fl, input bit h, input bit il, input bit rd);
        chk({tag, ".pc"},      32'(ifa.pc_o),          32'(pc));
        chk({tag, ".out"},     32'(ifa.out_o),         32'(out));
        chk({tag, ".out_vld"}, 32'(ifa.out_valid_o),   32'(ov));
        chk({tag, ".flags"},   32'(ifa.flags_o),       32'(fl));
        chk({tag, ".halted"},  32'(ifa.halted_o),      32'(h));
        chk({tag, ".illegal"}, 32'(ifa.illegal_o),     32'(il));
        chk({tag, ".ready"},   32'(ifa.instr_ready_o), 32'(rd));
    endtask

    // Reference model for the default configuration (8-bit data, 4 regs, 8-bit pc).
    int m_regs[4];
    int m_pc, m_out, m_prd;
    bit m_ov, m_z, m_b, m_c, m_halt, m_ill, m_pend;

    task automatic model_step(input bit r, input bit v, input logic [7:0] ins);
        int op, rd, rs, a, b, res, npc;
        if (r) begin
            for (int i = 0; i < 4; i++) m_regs[i] = i;
            m_pc = 0; m_out = 0; m_ov = 0; m_z = 0; m_b = 0; m_c = 0;
            m_halt = 0; m_ill = 0; m_pend = 0; m_prd = 0;
            return;
        end
        m_ov = 0;
        if (!v || m_halt) return;
        if (m_pend) begin
            m_regs[m_prd] = int'(ins);
            m_pend = 0;
            m_pc = (m_pc + 1) % 256;
            return;
        end
        op = int'(ins[7:4]); rd = int'(ins[3:2]); rs = int'(ins[1:0]);
        a = m_regs[rd]; b = m_regs[rs]; npc = m_pc + 1; res = 0;
        case (op)
            1:  begin res = (a + b) % 256;       m_c = (a + b) > 255; end
            2:  begin res = (a - b + 256) % 256; m_b = a < b;         end
            3:  res = a & b;
            4:  res = a | b;
            5:  res = a ^ b;
            6:  m_regs[rd] = b;
            7:  begin m_pend = 1; m_prd = rd; end
            8:  if (m_c) npc = m_pc + b;
            9:  if (m_b) npc = m_pc + b;
            10: npc = m_pc + b;
            11: begin m_out = b; m_ov = 1; end
            12: m_halt = 1;
            13, 14, 15: m_ill = 1;
            default: ;
        endcase
        if (op >= 1 && op <= 5) begin
            m_regs[rd] = res;
            m_z = (res == 0);
        end
        m_pc = npc % 256;
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        ifa.instr_valid_i = 1'b0; ifa.instr_i = '0;
        ifb.instr_valid_i = 1'b0; ifb.instr_i = '0;

        //                r  v  instr  pc  out   ov fl h  il rdy
        vecs.push_back(mk(1, 0, 8'h00,  0, 8'h00, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 8'h16,  1, 8'h00, 0, 0, 0, 0, 1)); // ADD r1,r2
        vecs.push_back(mk(1, 0, 8'h00,  0, 8'h00, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 8'h70,  1, 8'h00, 0, 0, 0, 0, 1)); // LDI r0
        vecs.push_back(mk(0, 1, 8'hFF,  2, 8'h00, 0, 0, 0, 0, 1)); // imm
        vecs.push_back(mk(0, 1, 8'h11,  3, 8'h00, 0, 5, 0, 0, 1)); // ADD r0,r1
        vecs.push_back(mk(0, 1, 8'h26,  4, 8'h00, 0, 3, 0, 0, 1)); // SUB r1,r2
        vecs.push_back(mk(0, 1, 8'h93,  7, 8'h00, 0, 3, 0, 0, 1)); // BB r3 taken
        vecs.push_back(mk(0, 1, 8'h2E,  8, 8'h00, 0, 1, 0, 0, 1)); // SUB r3,r2
        vecs.push_back(mk(0, 1, 8'h93,  9, 8'h00, 0, 1, 0, 0, 1)); // BB not taken
        vecs.push_back(mk(0, 1, 8'hB2, 10, 8'h02, 1, 1, 0, 0, 1)); // OUT r2
        vecs.push_back(mk(0, 0, 8'hB1, 10, 8'h02, 0, 1, 0, 0, 1)); // idle
        vecs.push_back(mk(0, 1, 8'hB2, 11, 8'h02, 1, 1, 0, 0, 1)); // OUT r2
        vecs.push_back(mk(0, 1, 8'hB1, 12, 8'hFF, 1, 1, 0, 0, 1)); // OUT r1 back-to-back
        vecs.push_back(mk(0, 1, 8'h00, 13, 8'hFF, 0, 1, 0, 0, 1)); // NOP
        vecs.push_back(mk(0, 1, 8'hE0, 14, 8'hFF, 0, 1, 0, 1, 1)); // reserved 14
        vecs.push_back(mk(0, 1, 8'hC0, 15, 8'hFF, 0, 1, 1, 1, 0)); // HALT
        vecs.push_back(mk(0, 1, 8'h15, 15, 8'hFF, 0, 1, 1, 1, 0)); // ignored
        vecs.push_back(mk(0, 1, 8'h00, 15, 8'hFF, 0, 1, 1, 1, 0)); // ignored
        vecs.push_back(mk(1, 1, 8'h00,  0, 8'h00, 0, 0, 0, 0, 1)); // rst wins
        vecs.push_back(mk(0, 1, 8'h74,  1, 8'h00, 0, 0, 0, 0, 1)); // LDI r1
        vecs.push_back(mk(1, 0, 8'h00,  0, 8'h00, 0, 0, 0, 0, 1)); // rst in IMM
        vecs.push_back(mk(0, 1, 8'h55,  1, 8'h00, 0, 4, 0, 0, 1)); // XOR r1,r1
        vecs.push_back(mk(0, 1, 8'hB5,  2, 8'h00, 1, 4, 0, 0, 1)); // OUT r1
        vecs.push_back(mk(0, 1, 8'hA0,  2, 8'h00, 0, 4, 0, 0, 1)); // BU r0=0 stalls
        vecs.push_back(mk(0, 1, 8'hA3,  5, 8'h00, 0, 4, 0, 0, 1)); // BU r3
        vecs.push_back(mk(0, 1, 8'h63,  6, 8'h00, 0, 4, 0, 0, 1)); // MOV r0,r3
        vecs.push_back(mk(0, 1, 8'hB0,  7, 8'h03, 1, 4, 0, 0, 1)); // OUT r0
        vecs.push_back(mk(0, 1, 8'h4B,  8, 8'h03, 0, 0, 0, 0, 1)); // OR r2,r3
        vecs.push_back(mk(0, 1, 8'h83,  9, 8'h03, 0, 0, 0, 0, 1)); // BC not taken

        for (int i = 0; i < vecs.size(); i++) begin
            rst_a = vecs[i].rst;
            ifa.instr_valid_i = vecs[i].valid;
            ifa.instr_i = vecs[i].instr;
            tick();
            check_a($sformatf("vec%0d", i), vecs[i].pc, vecs[i].out, vecs[i].ov,
                    vecs[i].flags, vecs[i].halt, vecs[i].ill, vecs[i].rdy);
        end

        rst_a = 1'b1; ifa.instr_valid_i = 1'b0;
        tick();
        model_step(1'b1, 1'b0, 8'h00);
        for (int n = 0; n < 2000; n++) begin
            logic [7:0] ins;
            bit r, v;
            r = ($urandom_range(0, 39) == 0);
            v = ($urandom_range(0, 3) != 0);
            ins = 8'($urandom);
            if (ins[7:4] == 4'hC && $urandom_range(0, 3) != 0) ins[7:4] = 4'h0;
            rst_a = r; ifa.instr_valid_i = v; ifa.instr_i = ins;
            tick();
            model_step(r, v, ins);
            check_a($sformatf("rnd%0d", n), m_pc, m_out, m_ov,
                    int'({m_z, m_b, m_c}), m_halt, m_ill, !m_halt);
        end
        rst_a = 1'b0; ifa.instr_valid_i = 1'b0;

        // Wide configuration: 16-bit data, 8 registers.
        rst_b = 1'b1;
        tick();
        chk("b.reset_pc", 32'(ifb.pc_o), 32'd0);
        rst_b = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ifb.instr_valid_i = 1'b1;
            ifb.instr_i = {4'hB, 3'd0, 3'(i)};
            tick();
            chk($sformatf("b.reg%0d", i), 32'(ifb.out_o), 32'(i));
            chk($sformatf("b.ov%0d", i), 32'(ifb.out_valid_o), 32'd1);
        end
        ifb.instr_i = {4'h7, 3'd7, 3'd0};
        tick();
        ifb.instr_i = 10'h3FF;
        tick();
        ifb.instr_i = {4'hB, 3'd0, 3'd7};
        tick();
        chk("b.ldi_zext", 32'(ifb.out_o), 32'h0000_03FF);
        chk("b.pc11", 32'(ifb.pc_o), 32'd11);
        ifb.instr_i = 10'h000;
        for (int i = 0; i < 244; i++) tick();
        chk("b.pc255", 32'(ifb.pc_o), 32'd255);
        tick();
        chk("b.pc_wrap", 32'(ifb.pc_o), 32'd0);
        ifb.instr_valid_i = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hidden_cpu_core.md
Name: hidden_cpu_core

Overview:
- Parametrised successor to the team's 8-pin, 4-register tiny CPU.
- Generalises data width, register count and PC width, and widens the opcode field to 4 bits.
- Adds behaviour the old core lacks:
  - two-word load-immediate (FSM),
  - valid/ready instruction handshake,
  - zero flag,
  - latched output port with a valid strobe,
  - HALT,
  - sticky illegal-opcode flag.
- Sits behind the pad wrapper; the wrapper serialises pins into instruction words.

Parameters:
- DATA_W, 8: register/ALU width (>=4).
- NREGS, 4: register count; power of two, >=2.
- PC_W, 8: program-counter width.
- ADDR_W, $clog2(NREGS): register-address width (derived, not overridable).
- INSTR_W, 4+2*ADDR_W: instruction width (derived).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- instr_i  in  INSTR_W  instruction word {opcode[3:0], rd[ADDR_W-1:0], rs[ADDR_W-1:0]}; the immediate word uses the same bus.
- instr_valid_i  in  1  instr_i is valid this cycle.
- instr_ready_o  out  1  core accepts the word; 0 only when halted.
- pc_o  out  PC_W  current PC.
- out_o  out  DATA_W  latched output register.
- out_valid_o  out  1  one-cycle pulse when out_o is updated.
- flags_o  out  3  {Z,B,C}.
- halted_o  out  1  core halted.
- illegal_o  out  1  sticky: a reserved opcode was seen.

Behaviour:
- Handshake and reset:
  - A word is accepted on a rising clk edge when instr_valid_i && instr_ready_o. With no acceptance, no architectural state changes, and out_valid_o is 0.
  - Reset values: pc 0; r[i]=i mod 2^DATA_W; flags 0; out_o 0; out_valid_o 0; halted_o 0; illegal_o 0; state FETCH; instr_ready_o 1.
- FSM states: FETCH, IMM, HALT.
  - FETCH -> IMM on accepted LDI.
  - IMM -> FETCH on the next accepted word.
  - FETCH -> HALT on accepted HALT.
  - HALT is left only via rst. Reset in IMM or HALT returns to FETCH; the pending LDI is discarded.
- PC: every accepted word, including the immediate word, advances pc by 1 unless a branch is taken. All PC arithmetic is mod 2^PC_W.
- Opcodes in FETCH (each takes effect at the accept edge):
  - 0 NOP.
  - 1 ADD: rd<=rd+rs; C<=carry out.
  - 2 SUB: rd<=rd-rs; B<=(rd<rs) unsigned.
  - 3 AND, 4 OR, 5 XOR: rd<=rd op rs.
  - Z<=(result==0) for opcodes 1-5. C is updated only by ADD, B only by SUB. Other flags hold.
  - 6 MOV: rd<=rs; flags unchanged.
  - 7 LDI: no write now; in IMM, rd<=zero-extended/truncated instr_i to DATA_W.
  - 8 BC, 9 BB, 10 BU:
    - if C / B / always: pc<=pc+r[rs] (zero-extended or truncated to PC_W);
    - else pc+1.
  - 11 OUT: out_o<=r[rs]; out_valid_o=1 for the following cycle only.
  - 12 HALT: pc+1, then halted; instr_ready_o=0 from the next cycle.
  - 13-15 reserved: executed as NOP; illegal_o<=1, cleared only by rst.
- Register operands are read from the pre-edge values; rd==rs is legal (e.g. SUB r,r gives 0, Z=1, B=0).
- A branch with r[rs]=0 stalls pc at the same value; this is legal.
- Back-to-back OUT produces consecutive valid pulses.

Decomposition:
- Package hidden_cpu_pkg:
  - opcode localparams (OP_NOP..OP_HALT);
  - state encoding {FETCH, IMM, HALT};
  - flag bit indices (FLAG_C=0, FLAG_B=1, FLAG_Z=2).
- Sub-module hidden_alu_n (DATA_W):
  - combinational; inputs opcode, a, b;
  - outputs result, carry, borrow, zero, write_en.
- The core holds the register array, PC, FSM, flags and output latch.

Test Plan:
- Reset then ADD r1,r2 (default params) -> r1=3, C=0, Z=0, pc=1.
- LDI r0 with imm 0xFF, then ADD r0,r1 -> after imm pc=2, r0=0xFF; after ADD r0=0x00, C=1, Z=1, pc=3.
- SUB r1,r2 (r1=1, r2=2) then BB r3 (r3=3) -> r1=0xFF, B=1; pc goes 1 -> 4. Repeat with B=0 -> pc+1.
- OUT r2 with instr_valid_i toggled 1,0,1 -> out_o=2 with a single-cycle out_valid_o; idle cycles leave pc unchanged.
- Opcode 14, then HALT, then valid words -> illegal_o=1 stays set, instr_ready_o=0, pc frozen; rst clears all.
- rst asserted while in IMM, then valid word 0x55 -> word decoded as an opcode in FETCH, not written as an immediate; rerun with DATA_W=16, NREGS=8: regs reset 0..7, pc wraps 0xFF->0x00.
